finalproject_soc_onchip_mem_byte_loader: RTL

//  Upstream Avalon-MM write master for the 4-word x 32-bit on-chip RAM (single port, 1-cycle read latency).

---
 rtl/finalproject_soc_onchip_mem_byte_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/finalproject_soc_onchip_mem_byte_loader.sv
// Byte-stream to 32-bit word loader for a small single-port on-chip RAM.
// Optional readback verification is enabled by defining ONCHIP_LOADER_READBACK_EN.
module finalproject_soc_onchip_mem_byte_loader #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        st_data,
  input  logic              st_valid,
  input  logic              st_eop,
  output logic              st_ready,
  input  logic              flush,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic              clken,
  input  logic [31:0]       readdata,
  output logic              busy,
  output logic [CNT_W-1:0]  words_written,
  output logic              mismatch
);

  typedef enum logic [1:0] {StFill, StWrite, StRd, StCmp} state_e;

  state_e              state_q, state_d;
  logic [2:0]          count_q, count_d, cnt_next;
  logic [7:0]          lane_q [4];
  logic                eop_q, eop_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    words_q;
  logic                st_ready_q;
  logic                accept;
  logic                advance;
  logic [3:0]          be_fill;
  logic [31:0]         lane_mask;
  logic [31:0]         word_raw;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    eop_d    = eop_q;
    accept   = 1'b0;
    cnt_next = count_q;
    unique case (state_q)
      StFill: begin
        accept   = st_valid & st_ready_q;
        cnt_next = count_q + {2'b00, accept};
        count_d  = cnt_next;
        // eop wins over flush; flush with nothing packed is ignored
        if ((cnt_next == 3'd4) || (accept && st_eop) || (flush && (cnt_next != 3'd0))) begin
          state_d = StWrite;
          eop_d   = accept & st_eop;
        end
      end
      StWrite: begin
`ifdef ONCHIP_LOADER_READBACK_EN
        state_d = StRd;
`else
        state_d = StFill;
        count_d = 3'd0;
`endif
      end
      StRd: state_d = StCmp;
      StCmp: begin
        state_d = StFill;
        count_d = 3'd0;
      end
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    unique case (count_q)
      3'd1:    be_fill = 4'b0001;
      3'd2:    be_fill = 4'b0011;
      3'd3:    be_fill = 4'b0111;
      3'd4:    be_fill = 4'b1111;
      default: be_fill = 4'b0000;
    endcase
    lane_mask = '0;
    for (int i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{be_fill[i]}};
    end
    word_raw = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};
  end

`ifdef ONCHIP_LOADER_READBACK_EN
  assign advance = (state_q == StCmp);
`else
  assign advance = (state_q == StWrite);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFill;
      count_q    <= 3'd0;
      eop_q      <= 1'b0;
      addr_q     <= '0;
      words_q    <= '0;
      st_ready_q <= 1'b0;
      for (int i = 0; i < 4; i++) lane_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      eop_q      <= eop_d;
      st_ready_q <= (state_d == StFill);
      if (accept) lane_q[count_q[1:0]] <= st_data;
      if (advance) begin
        if (eop_q || (addr_q == ADDR_W'(DEPTH - 1))) addr_q <= '0;
        else                                          addr_q <= addr_q + 1'b1;
      end
      if ((state_q == StWrite) && (words_q != '1)) words_q <= words_q + 1'b1;
    end
  end

`ifdef ONCHIP_LOADER_READBACK_EN
  logic mismatch_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_q <= 1'b0;
    end else if ((state_q == StCmp) && (((readdata ^ word_raw) & lane_mask) != 32'h0)) begin
      mismatch_q <= 1'b1;
    end
  end

  assign mismatch   = mismatch_q;
  assign chipselect = (state_q == StWrite) || (state_q == StRd);
`else
  logic unused_readdata;
  assign unused_readdata = ^readdata;
  assign mismatch        = 1'b0;
  assign chipselect      = (state_q == StWrite);
`endif

  assign write         = (state_q == StWrite);
  assign byteenable    = write ? be_fill : 4'b0000;
  assign writedata     = write ? (word_raw & lane_mask) : 32'h0;
  assign address       = addr_q;
  assign clken         = 1'b1;
  assign st_ready      = st_ready_q;
  assign busy          = (state_q != StFill) || (count_q != 3'd0);
  assign words_written = words_q;

endmodule
